// File: rtl/img_rx_pkg.sv
// Shared constants and state encodings for the photo-frame image receive path.
package img_rx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PIX_W  = 12;
    localparam int unsigned CNT_W  = 15;

    localparam logic [BYTE_W-1:0] MARKER_DEF = 8'h5A;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [3:0] {
        RX_IDLE  = 4'd0,
        RX_START = 4'd1,
        RX_DATA  = 4'd2,
        RX_STOP  = 4'd3
    } rx_state_t;

    typedef enum logic [7:0] {
        FR_IDLE      = 8'd1,
        FR_RECEIVING = 8'd2,
        FR_DONE      = 8'd3
    } fr_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, framing-error drop.
module uart_rx
    import img_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [BYTE_W-1:0] data,
    output logic              flag,
    output logic [3:0]        state
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF    = BIT_CYC / 2;
    localparam int unsigned TMR_W   = $clog2(BIT_CYC + 1);

    rx_state_t         st, st_nxt;
    logic              rx_s1, rx_s2, rx_q;
    logic [TMR_W-1:0]  tmr;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shreg;
    logic              bit_end, half_end, fall;

    assign bit_end  = (tmr == TMR_W'(BIT_CYC - 1));
    assign half_end = (tmr == TMR_W'(HALF - 1));
    assign fall     = rx_q & ~rx_s2;
    assign state    = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= RX_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            RX_IDLE:  if (fall) st_nxt = RX_START;
            RX_START: if (half_end) st_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_end && bit_idx == 3'd7) st_nxt = RX_STOP;
            RX_STOP:  if (bit_end) st_nxt = RX_IDLE;
            default:  st_nxt = RX_IDLE;
        endcase
    end

    // Synchroniser, bit timer, shift register and registered byte output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_q    <= 1'b1;
            tmr     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data    <= '0;
            flag    <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
            flag  <= 1'b0;
            if (st != st_nxt || (st == RX_DATA && bit_end)) tmr <= '0;
            else if (st != RX_IDLE)                         tmr <= tmr + TMR_W'(1);
            if (st == RX_START) bit_idx <= '0;
            if (st == RX_DATA && bit_end) begin
                shreg   <= {rx_s2, shreg[BYTE_W-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (st == RX_STOP && bit_end && rx_s2) begin
                data <= shreg;
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/img_rx_top.sv
// Image receive path: UART bytes framed by MARKER, payload packed into RGB444 pixels.
module img_rx_top
    import img_rx_pkg::*;
#(
    parameter int unsigned       CLK_FREQ  = 50_000_000,
    parameter int unsigned       BAUD_RATE = 9600,
    parameter logic [BYTE_W-1:0] MARKER    = MARKER_DEF
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_test_rcv,
    output logic              o_test_rcv_flag,
    output logic [BYTE_W-1:0] o_test_rcv_data,
    output logic              o_test_scd_flag,
    output logic [BYTE_W-1:0] o_test_scd_data,
    output logic [PIX_W-1:0]  o_test_pix_data,
    output logic              o_test_pix_valid,
    output logic              o_test_receiving,
    output logic [7:0]        o_test_state,
    output logic [3:0]        o_test_rcv_state,
    output logic [CNT_W-1:0]  o_test_pix_cnt
);

    logic              rcv_flag;
    logic [BYTE_W-1:0] rcv_data;
    fr_state_t         st, st_nxt;
    logic              fwd, clr, phase;
    logic [3:0]        hi_nib;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_uart_rx (
        .clk  (i_clk_sys),
        .rst_n(i_rst_n),
        .rx   (i_test_rcv),
        .data (rcv_data),
        .flag (rcv_flag),
        .state(o_test_rcv_state)
    );

    assign o_test_rcv_flag = rcv_flag;
    assign o_test_rcv_data = rcv_data;
    assign o_test_state    = st;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st               <= FR_IDLE;
            o_test_receiving <= 1'b0;
        end else begin
            st               <= st_nxt;
            o_test_receiving <= (st_nxt == FR_RECEIVING);
        end
    end

    // A MARKER seen at phase 0 closes the frame; at phase 1 it is pixel data.
    always_comb begin
        st_nxt = st;
        fwd    = 1'b0;
        clr    = 1'b0;
        if (rcv_flag) begin
            case (st)
                FR_IDLE, FR_DONE: begin
                    if (rcv_data == MARKER) begin
                        st_nxt = FR_RECEIVING;
                        clr    = 1'b1;
                    end
                end
                FR_RECEIVING: begin
                    if (!phase && rcv_data == MARKER) st_nxt = FR_DONE;
                    else                              fwd    = 1'b1;
                end
                default: st_nxt = FR_IDLE;
            endcase
        end
    end

    // Payload forwarding and pixel packing; the high byte's upper nibble is unused.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_test_scd_flag  <= 1'b0;
            o_test_scd_data  <= '0;
            o_test_pix_data  <= '0;
            o_test_pix_valid <= 1'b0;
            o_test_pix_cnt   <= '0;
            phase            <= 1'b0;
            hi_nib           <= '0;
        end else begin
            o_test_scd_flag  <= fwd;
            o_test_pix_valid <= 1'b0;
            if (fwd) o_test_scd_data <= rcv_data;
            if (clr) begin
                phase          <= 1'b0;
                o_test_pix_cnt <= '0;
            end else if (o_test_scd_flag) begin
                if (!phase) begin
                    hi_nib <= o_test_scd_data[3:0];
                    phase  <= 1'b1;
                end else begin
                    o_test_pix_data  <= {hi_nib, o_test_scd_data};
                    o_test_pix_valid <= 1'b1;
                    phase            <= 1'b0;
                    if (o_test_pix_cnt != CNT_MAX) o_test_pix_cnt <= o_test_pix_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_img_rx_top.sv
// Scoreboard bench for img_rx_top at a reduced bit period of 16 clocks.
module tb_img_rx_top;
    import img_rx_pkg::*;

    localparam int unsigned CLK_F = 1_600_000;
    localparam int unsigned BAUD  = 100_000;
    localparam int unsigned BIT   = CLK_F / BAUD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        rcv_flag, scd_flag, pix_valid, receiving;
    logic [7:0]  rcv_data, scd_data, state;
    logic [11:0] pix_data;
    logic [3:0]  rcv_state;
    logic [14:0] pix_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0]  q_rcv[$];
    logic [7:0]  q_scd[$];
    logic [11:0] q_pix[$];
    logic [14:0] q_cnt[$];

    int         m_state = 1;
    bit         m_phase = 1'b0;
    logic [3:0] m_hi    = '0;
    int         m_cnt   = 0;

    always #5 clk = ~clk;

    img_rx_top #(.CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .MARKER(8'h5A)) dut (
        .i_clk_sys       (clk),
        .i_rst_n         (rst_n),
        .i_test_rcv      (rx),
        .o_test_rcv_flag (rcv_flag),
        .o_test_rcv_data (rcv_data),
        .o_test_scd_flag (scd_flag),
        .o_test_scd_data (scd_data),
        .o_test_pix_data (pix_data),
        .o_test_pix_valid(pix_valid),
        .o_test_receiving(receiving),
        .o_test_state    (state),
        .o_test_rcv_state(rcv_state),
        .o_test_pix_cnt  (pix_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame/packer reference: decides which flags and values each good byte should produce.
    task automatic model_byte(input logic [7:0] b);
        q_rcv.push_back(b);
        if (m_state != 2) begin
            if (b == 8'h5A) begin
                m_state = 2;
                m_cnt   = 0;
                m_phase = 1'b0;
            end
        end else if (!m_phase && b == 8'h5A) begin
            m_state = 3;
        end else begin
            q_scd.push_back(b);
            if (!m_phase) begin
                m_hi    = b[3:0];
                m_phase = 1'b1;
            end else begin
                m_cnt = (m_cnt < 32767) ? m_cnt + 1 : m_cnt;
                q_pix.push_back({m_hi, b});
                q_cnt.push_back(15'(m_cnt));
                m_phase = 1'b0;
            end
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        drive_byte(b, 1'b1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_state"}, 32'(state), 32'(m_state));
        check({tag, "_receiving"}, 32'(receiving), 32'(m_state == 2));
        check({tag, "_pix_cnt"}, 32'(pix_cnt), 32'(m_cnt));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rcv_flag"}, 32'(rcv_flag), 0);
        check({tag, "_rcv_data"}, 32'(rcv_data), 0);
        check({tag, "_scd_flag"}, 32'(scd_flag), 0);
        check({tag, "_scd_data"}, 32'(scd_data), 0);
        check({tag, "_pix_data"}, 32'(pix_data), 0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 0);
        check({tag, "_receiving"}, 32'(receiving), 0);
        check({tag, "_state"}, 32'(state), 1);
        check({tag, "_rcv_state"}, 32'(rcv_state), 0);
        check({tag, "_pix_cnt"}, 32'(pix_cnt), 0);
    endtask

    // Output monitor: every pulse must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rcv_flag) begin
                if (q_rcv.size() > 0) check("rcv_data", 32'(rcv_data), 32'(q_rcv.pop_front()));
                else                  check("rcv_unexpected", 1, 0);
            end
            if (scd_flag) begin
                if (q_scd.size() > 0) check("scd_data", 32'(scd_data), 32'(q_scd.pop_front()));
                else                  check("scd_unexpected", 1, 0);
            end
            if (pix_valid) begin
                if (q_pix.size() > 0) begin
                    check("pix_data", 32'(pix_data), 32'(q_pix.pop_front()));
                    check("pix_cnt_at_valid", 32'(pix_cnt), 32'(q_cnt.pop_front()));
                end else begin
                    check("pix_unexpected", 1, 0);
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check_reset("in_reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset("idle");

        send(8'h5A);
        check_frame("start");

        for (int p = 0; p < 5; p++) begin
            send(8'h73);
            send(8'h28);
            check_frame("pair");
        end

        send(8'h5A);
        check_frame("done");
        check("done_pix_data", 32'(pix_data), 32'h328);

        send(8'h11);
        check_frame("done_ignore");

        send(8'h5A);
        check_frame("restart");
        send(8'h73);
        send(8'h5A);
        check_frame("marker_as_data");
        check("marker_pix_data", 32'(pix_data), 32'h35A);

        drive_byte(8'hA5, 1'b0);
        repeat (BIT) @(negedge clk);
        check("frame_err_rcv_state", 32'(rcv_state), 0);
        check_frame("frame_err");

        @(negedge clk) rx = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_rcv_state", 32'(rcv_state), 0);
        check_frame("glitch");

        @(negedge clk) rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("mid_byte_rcv_state", 32'(rcv_state), 2);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        m_state = 1;
        m_cnt   = 0;
        m_phase = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset("post_reset");

        send(8'h5A);
        check_frame("recover");

        repeat (BIT) @(negedge clk);
        check("rcv_pending", q_rcv.size(), 0);
        check("scd_pending", q_scd.size(), 0);
        check("pix_pending", q_pix.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
